// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle RV32I sequencer:
// FSM states, PC-next selects and reused decoder fields.
package multicycle_control_pkg;

   typedef enum logic [2:0] {
      ST_FETCH     = 3'd0,
      ST_DECODE    = 3'd1,
      ST_EXECUTE   = 3'd2,
      ST_MEM       = 3'd3,
      ST_WRITEBACK = 3'd4,
      ST_HALT      = 3'd5
   } state_e;

   typedef enum logic [1:0] {
      PC_PLUS4  = 2'b00,
      PC_JAL    = 2'b01,
      PC_JALR   = 2'b10,
      PC_BRANCH = 2'b11
   } pc_sel_e;

   localparam logic [1:0] INPUT_REG_MEM = 2'b10;
   localparam logic [1:0] JMP_JAL       = 2'b01;
   localparam logic [1:0] JMP_JALR      = 2'b10;

endpackage

// File: rtl/multicycle_control_if.sv
// Instruction/data memory handshake bundle between
// the sequencer (master) and the memory side (slave).
interface multicycle_control_if;

   logic imem_req;
   logic imem_ready;
   logic ir_we;
   logic dmem_req;
   logic dmem_we;
   logic dmem_ready;

   modport master (
      output imem_req,
      output ir_we,
      output dmem_req,
      output dmem_we,
      input  imem_ready,
      input  dmem_ready
   );

   modport slave (
      input  imem_req,
      input  ir_we,
      input  dmem_req,
      input  dmem_we,
      output imem_ready,
      output dmem_ready
   );

endinterface

// File: rtl/multicycle_control_pc_next_select.sv
// PC-next priority encoder: jal, then jalr, then taken
// branch, else pc+4.
module pc_next_select
   import multicycle_control_pkg::*;
(
   input  logic [1:0] jmp_pc_i,
   input  logic       b_pc_i,
   input  logic       branch_taken_i,
   output pc_sel_e    pc_sel_o
);

   always_comb begin
      pc_sel_o = PC_PLUS4;
      priority case (1'b1)
         (jmp_pc_i == JMP_JAL):     pc_sel_o = PC_JAL;
         (jmp_pc_i == JMP_JALR):    pc_sel_o = PC_JALR;
         (b_pc_i & branch_taken_i): pc_sel_o = PC_BRANCH;
         default:                   pc_sel_o = PC_PLUS4;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXECUTE/
// MEM/WRITEBACK/HALT with memory handshakes and instret.
module multicycle_control
   import multicycle_control_pkg::*;
#(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   multicycle_control_if.master mem,
   input  logic                 dec_we_reg,
   input  logic                 dec_mem_we,
   input  logic [1:0]           dec_input_reg,
   input  logic [1:0]           dec_jmp_pc,
   input  logic                 dec_b_pc,
   input  logic                 branch_taken,
   output logic                 rf_we,
   output logic                 pc_we,
   output logic [1:0]           pc_sel,
   input  logic                 halt,
   output logic                 halted,
   output logic [2:0]           state,
   output logic [CNT_WIDTH-1:0] instret
);

   state_e               state_q, state_d;
   logic [CNT_WIDTH-1:0] instret_q, instret_d;

   logic    is_load, is_store;
   logic    imem_req_s, ir_we_s, dmem_req_s, dmem_we_s;
   logic    rf_we_s, pc_we_s;
   pc_sel_e pc_sel_s, wb_sel;

   assign is_load  = dec_we_reg & (dec_input_reg == INPUT_REG_MEM);
   assign is_store = dec_mem_we;

   pc_next_select u_pc_sel (
      .jmp_pc_i       (dec_jmp_pc),
      .b_pc_i         (dec_b_pc),
      .branch_taken_i (branch_taken),
      .pc_sel_o       (wb_sel)
   );

   always_comb begin
      state_d    = state_q;
      instret_d  = instret_q;
      imem_req_s = 1'b0;
      ir_we_s    = 1'b0;
      dmem_req_s = 1'b0;
      dmem_we_s  = 1'b0;
      rf_we_s    = 1'b0;
      pc_we_s    = 1'b0;
      pc_sel_s   = PC_PLUS4;
      case (state_q)
         ST_FETCH: begin
            if (halt) begin
               state_d = ST_HALT;
            end else begin
               imem_req_s = 1'b1;
               if (mem.imem_ready) begin
                  ir_we_s = 1'b1;
                  state_d = ST_DECODE;
               end
            end
         end
         ST_DECODE:  state_d = ST_EXECUTE;
         ST_EXECUTE: begin
            state_d = (is_load | is_store) ? ST_MEM : ST_WRITEBACK;
         end
         ST_MEM: begin
            dmem_req_s = 1'b1;
            dmem_we_s  = is_store;
            // Stores retire here; loads still need the rd write.
            if (mem.dmem_ready) begin
               if (is_store) begin
                  pc_we_s   = 1'b1;
                  instret_d = instret_q + CNT_WIDTH'(1);
                  state_d   = ST_FETCH;
               end else begin
                  state_d = ST_WRITEBACK;
               end
            end
         end
         ST_WRITEBACK: begin
            rf_we_s   = dec_we_reg;
            pc_we_s   = 1'b1;
            pc_sel_s  = wb_sel;
            instret_d = instret_q + CNT_WIDTH'(1);
            state_d   = ST_FETCH;
         end
         ST_HALT: begin
            if (!halt) state_d = ST_FETCH;
         end
         default: state_d = ST_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_FETCH;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         instret_q <= instret_d;
      end
   end

   // Strobes are gated so nothing fires while reset is held.
   assign mem.imem_req = rst_n & imem_req_s;
   assign mem.ir_we    = rst_n & ir_we_s;
   assign mem.dmem_req = rst_n & dmem_req_s;
   assign mem.dmem_we  = rst_n & dmem_we_s;
   assign rf_we        = rst_n & rf_we_s;
   assign pc_we        = rst_n & pc_we_s;
   assign pc_sel       = rst_n ? pc_sel_s : PC_PLUS4;
   assign halted       = rst_n & (state_q == ST_HALT);
   assign state        = state_q;
   assign instret      = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed vector bench for multicycle_control with a
// small instret width so the wrap is reachable.
module tb_multicycle_control;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          dec_we_reg, dec_mem_we, dec_b_pc;
   logic          branch_taken, halt;
   logic [1:0]    dec_input_reg, dec_jmp_pc;
   logic          rf_we, pc_we, halted;
   logic [1:0]    pc_sel;
   logic [2:0]    state;
   logic [CW-1:0] instret;

   int n_cmp = 0;
   int n_bad = 0;

   multicycle_control_if mif ();

   multicycle_control #(.CNT_WIDTH(CW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .mem           (mif),
      .dec_we_reg    (dec_we_reg),
      .dec_mem_we    (dec_mem_we),
      .dec_input_reg (dec_input_reg),
      .dec_jmp_pc    (dec_jmp_pc),
      .dec_b_pc      (dec_b_pc),
      .branch_taken  (branch_taken),
      .rf_we         (rf_we),
      .pc_we         (pc_we),
      .pc_sel        (pc_sel),
      .halt          (halt),
      .halted        (halted),
      .state         (state),
      .instret       (instret)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic ir, dr, we, mw;
      logic [1:0] isrc, jmp;
      logic bpc, tk, hlt;
      logic [2:0] st;
      logic imq, irw, dq, dw, rfw, pcw;
      logic [1:0] ps;
      logic hd;
      logic [3:0] ins;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(
      logic ir, logic dr, logic we, logic mw,
      logic [1:0] isrc, logic [1:0] jmp,
      logic bpc, logic tk, logic hlt,
      logic [2:0] st, logic imq, logic irw,
      logic dq, logic dw, logic rfw, logic pcw,
      logic [1:0] ps, logic hd, logic [3:0] ins);
      vec_t r;
      r.ir = ir; r.dr = dr; r.we = we; r.mw = mw;
      r.isrc = isrc; r.jmp = jmp;
      r.bpc = bpc; r.tk = tk; r.hlt = hlt;
      r.st = st; r.imq = imq; r.irw = irw;
      r.dq = dq; r.dw = dw; r.rfw = rfw; r.pcw = pcw;
      r.ps = ps; r.hd = hd; r.ins = ins;
      return r;
   endfunction

   task automatic chk(string nm, int idx,
                      logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s [%0d]: got %0h expected %0h",
                  nm, idx, act, exp);
      end
   endtask

   task automatic chk_all(int i, vec_t e);
      chk("state", i, 32'(state), 32'(e.st));
      chk("imem_req", i, 32'(mif.imem_req), 32'(e.imq));
      chk("ir_we", i, 32'(mif.ir_we), 32'(e.irw));
      chk("dmem_req", i, 32'(mif.dmem_req), 32'(e.dq));
      chk("dmem_we", i, 32'(mif.dmem_we), 32'(e.dw));
      chk("rf_we", i, 32'(rf_we), 32'(e.rfw));
      chk("pc_we", i, 32'(pc_we), 32'(e.pcw));
      chk("pc_sel", i, 32'(pc_sel), 32'(e.ps));
      chk("halted", i, 32'(halted), 32'(e.hd));
      chk("instret", i, 32'(instret), 32'(e.ins));
      chk("ir_pc_excl", i, 32'(mif.ir_we & pc_we), 32'd0);
   endtask

   task automatic drive(vec_t e);
      mif.imem_ready = e.ir;
      mif.dmem_ready = e.dr;
      dec_we_reg     = e.we;
      dec_mem_we     = e.mw;
      dec_input_reg  = e.isrc;
      dec_jmp_pc     = e.jmp;
      dec_b_pc       = e.bpc;
      branch_taken   = e.tk;
      halt           = e.hlt;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(v(1,1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0));
      // ADD
      tbl.push_back(v(1,0,1,0,1,0,0,0,0, 0,1,1,0,0,0,0,0,0,0));
      tbl.push_back(v(1,0,1,0,1,0,0,0,0, 1,0,0,0,0,0,0,0,0,0));
      tbl.push_back(v(1,0,1,0,1,0,0,0,0, 2,0,0,0,0,0,0,0,0,0));
      tbl.push_back(v(1,0,1,0,1,0,0,0,0, 4,0,0,0,0,1,1,0,0,0));
      // load, dmem_ready after 3 wait cycles
      tbl.push_back(v(1,0,1,0,2,0,0,0,0, 0,1,1,0,0,0,0,0,0,1));
      tbl.push_back(v(1,0,1,0,2,0,0,0,0, 1,0,0,0,0,0,0,0,0,1));
      tbl.push_back(v(1,0,1,0,2,0,0,0,0, 2,0,0,0,0,0,0,0,0,1));
      tbl.push_back(v(1,0,1,0,2,0,0,0,0, 3,0,0,1,0,0,0,0,0,1));
      tbl.push_back(v(1,0,1,0,2,0,0,0,0, 3,0,0,1,0,0,0,0,0,1));
      tbl.push_back(v(1,0,1,0,2,0,0,0,0, 3,0,0,1,0,0,0,0,0,1));
      tbl.push_back(v(1,1,1,0,2,0,0,0,0, 3,0,0,1,0,0,0,0,0,1));
      tbl.push_back(v(1,0,1,0,2,0,0,0,0, 4,0,0,0,0,1,1,0,0,1));
      // store, zero wait
      tbl.push_back(v(1,0,0,1,0,0,0,0,0, 0,1,1,0,0,0,0,0,0,2));
      tbl.push_back(v(1,0,0,1,0,0,0,0,0, 1,0,0,0,0,0,0,0,0,2));
      tbl.push_back(v(1,0,0,1,0,0,0,0,0, 2,0,0,0,0,0,0,0,0,2));
      tbl.push_back(v(1,1,0,1,0,0,0,0,0, 3,0,0,1,1,0,1,0,0,2));
      // branch taken
      tbl.push_back(v(1,0,0,0,0,0,1,1,0, 0,1,1,0,0,0,0,0,0,3));
      tbl.push_back(v(1,0,0,0,0,0,1,1,0, 1,0,0,0,0,0,0,0,0,3));
      tbl.push_back(v(1,0,0,0,0,0,1,1,0, 2,0,0,0,0,0,0,0,0,3));
      tbl.push_back(v(1,0,0,0,0,0,1,1,0, 4,0,0,0,0,0,1,3,0,3));
      // branch not taken
      tbl.push_back(v(1,0,0,0,0,0,1,0,0, 0,1,1,0,0,0,0,0,0,4));
      tbl.push_back(v(1,0,0,0,0,0,1,0,0, 1,0,0,0,0,0,0,0,0,4));
      tbl.push_back(v(1,0,0,0,0,0,1,0,0, 2,0,0,0,0,0,0,0,0,4));
      tbl.push_back(v(1,0,0,0,0,0,1,0,0, 4,0,0,0,0,0,1,0,0,4));
      // jal
      tbl.push_back(v(1,0,1,0,0,1,0,0,0, 0,1,1,0,0,0,0,0,0,5));
      tbl.push_back(v(1,0,1,0,0,1,0,0,0, 1,0,0,0,0,0,0,0,0,5));
      tbl.push_back(v(1,0,1,0,0,1,0,0,0, 2,0,0,0,0,0,0,0,0,5));
      tbl.push_back(v(1,0,1,0,0,1,1,1,0, 4,0,0,0,0,1,1,1,0,5));
      // jalr
      tbl.push_back(v(1,0,1,0,0,2,0,0,0, 0,1,1,0,0,0,0,0,0,6));
      tbl.push_back(v(1,0,1,0,0,2,0,0,0, 1,0,0,0,0,0,0,0,0,6));
      tbl.push_back(v(1,0,1,0,0,2,0,0,0, 2,0,0,0,0,0,0,0,0,6));
      tbl.push_back(v(1,0,1,0,0,2,1,1,0, 4,0,0,0,0,1,1,2,0,6));
      // NOP with one imem wait; stray dmem_ready
      tbl.push_back(v(0,1,0,0,0,0,0,1,0, 0,1,0,0,0,0,0,0,0,7));
      tbl.push_back(v(1,0,0,0,0,0,0,1,0, 0,1,1,0,0,0,0,0,0,7));
      tbl.push_back(v(1,1,0,0,0,0,0,1,0, 1,0,0,0,0,0,0,0,0,7));
      tbl.push_back(v(1,1,0,0,0,0,0,1,0, 2,0,0,0,0,0,0,0,0,7));
      tbl.push_back(v(1,1,0,0,0,0,0,1,0, 4,0,0,0,0,0,1,0,0,7));
      // ADD with halt raised in EXECUTE
      tbl.push_back(v(1,0,1,0,1,0,0,0,0, 0,1,1,0,0,0,0,0,0,8));
      tbl.push_back(v(1,0,1,0,1,0,0,0,0, 1,0,0,0,0,0,0,0,0,8));
      tbl.push_back(v(1,0,1,0,1,0,0,0,1, 2,0,0,0,0,0,0,0,0,8));
      tbl.push_back(v(1,0,1,0,1,0,0,0,1, 4,0,0,0,0,1,1,0,0,8));
      tbl.push_back(v(1,0,1,0,1,0,0,0,1, 0,0,0,0,0,0,0,0,0,9));
      tbl.push_back(v(1,0,1,0,1,0,0,0,1, 5,0,0,0,0,0,0,0,1,9));
      tbl.push_back(v(1,0,1,0,1,0,0,0,0, 5,0,0,0,0,0,0,0,1,9));
      // store that gets reset in MEM
      tbl.push_back(v(1,0,0,1,0,0,0,0,0, 0,1,1,0,0,0,0,0,0,9));
      tbl.push_back(v(1,0,0,1,0,0,0,0,0, 1,0,0,0,0,0,0,0,0,9));
      tbl.push_back(v(1,0,0,1,0,0,0,0,0, 2,0,0,0,0,0,0,0,0,9));
      tbl.push_back(v(1,0,0,1,0,0,0,0,0, 3,0,0,1,1,0,0,0,0,9));

      // reset state
      @(negedge clk);
      @(negedge clk);
      #1;
      chk_all(-1, v(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0));
      @(negedge clk);
      rst_n = 1'b1;
      drive(v(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0));

      foreach (tbl[i]) begin
         @(negedge clk);
         drive(tbl[i]);
         #1;
         chk_all(i, tbl[i]);
      end

      // async reset mid store, before the ready edge
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_state", 0, 32'(state), 32'd0);
      chk("rst_dmem_req", 0, 32'(mif.dmem_req), 32'd0);
      chk("rst_dmem_we", 0, 32'(mif.dmem_we), 32'd0);
      chk("rst_pc_we", 0, 32'(pc_we), 32'd0);
      chk("rst_instret", 0, 32'(instret), 32'd0);
      mif.dmem_ready = 1'b1;
      mif.imem_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 2; k++) begin
         #1;
         chk("post_state", k, 32'(state), 32'd0);
         chk("post_pc_we", k, 32'(pc_we), 32'd0);
         chk("post_dmem_we", k, 32'(mif.dmem_we), 32'd0);
         chk("post_imem_req", k, 32'(mif.imem_req), 32'd1);
         if (k == 0) @(negedge clk);
      end

      // 16 NOPs from zero: 15 reach max, the 16th wraps
      drive(v(1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0));
      for (int k = 0; k < 60; k++) @(negedge clk);
      #1;
      chk("pre_wrap_state", 0, 32'(state), 32'd0);
      chk("pre_wrap_instret", 0, 32'(instret), 32'd15);
      for (int k = 0; k < 4; k++) @(negedge clk);
      #1;
      chk("wrap_instret", 0, 32'(instret), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
